// File: rtl/fib_sequence_engine.sv
// Fibonacci sequence engine.
// Emits a Fibonacci-style term stream starting from two seed terms over a
// valid/ready handshake. Three overflow policies are supported:
//   - wrap:     keep the low WIDTH bits of each sum
//   - saturate: force all-ones once a sum carries out
//   - stop:     end the run just before the first overflowed term
// A run can be cancelled with abort or with reset.
module fib_sequence_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    input  logic [CNT_W-1:0] num_terms,
    input  logic [1:0]       mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] term_idx,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_EMIT   = 1'b1;
    localparam logic [1:0] MODE_SAT  = 2'd1;
    localparam logic [1:0] MODE_STOP = 2'd2;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] cur_q, cur_d;      // term currently presented
    logic [WIDTH-1:0] nxt_q, nxt_d;      // term that follows cur
    logic             nxt_ovf_q, nxt_ovf_d;
    logic [CNT_W-1:0] rem_q, rem_d;      // terms still allowed, including cur
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [1:0]       mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum;
    logic             carry;
    logic [WIDTH-1:0] next_term;
    logic             emitting;
    logic             last;
    logic             xfer;

    // The extra sum bit is the carry; only saturate mode alters the stored term.
    assign emitting  = (state_q == ST_EMIT);
    assign sum       = {1'b0, cur_q} + {1'b0, nxt_q};
    assign carry     = sum[WIDTH];
    assign next_term = (mode_q == MODE_SAT && carry) ? '1 : sum[WIDTH-1:0];

    // In stop mode the current term is final when the following term has
    // already overflowed, so an overflowed term is never presented.
    assign last = emitting &&
                  ((rem_q == CNT_W'(1)) || (mode_q == MODE_STOP && nxt_ovf_q));
    assign xfer = emitting && out_ready;

    assign out_valid = emitting;
    assign out_data  = emitting ? cur_q : '0;
    assign out_last  = last;
    assign term_idx  = idx_q;
    assign busy      = emitting;
    assign done      = done_q;
    assign overflow  = ovf_q;

    // Next-state logic for the run controller and the term pipeline.
    always_comb begin
        // NOTE: every signal gets a default here, so no path can leave one
        // unassigned and infer a latch.
        state_d   = state_q;
        cur_d     = cur_q;
        nxt_d     = nxt_q;
        nxt_ovf_d = nxt_ovf_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_terms != '0) begin
                        cur_d     = seed_a;
                        nxt_d     = seed_b;
                        nxt_ovf_d = 1'b0;
                        rem_d     = num_terms;
                        mode_d    = mode;
                        idx_d     = '0;
                        ovf_d     = 1'b0;
                        state_d   = ST_EMIT;
                    end else begin
                        // Zero-length run: nothing to emit, just complete.
                        done_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (abort) begin
                    // Abort wins over a simultaneous transfer and does not signal done.
                    state_d = ST_IDLE;
                end else if (xfer) begin
                    if (last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cur_d     = nxt_q;
                        nxt_d     = next_term;
                        nxt_ovf_d = carry;
                        rem_d     = rem_q - CNT_W'(1);
                        idx_d     = idx_q + CNT_W'(1);
                        ovf_d     = ovf_q | carry;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            nxt_q     <= '0;
            nxt_ovf_q <= 1'b0;
            rem_q     <= '0;
            idx_q     <= '0;
            mode_q    <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            nxt_q     <= nxt_d;
            nxt_ovf_q <= nxt_ovf_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: doc/fib_sequence_engine.md
FIB_SEQUENCE_ENGINE -- requirements
Module: fib_sequence_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the bit width of every sequence term.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the bit width of the term-count and term-index fields.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, meaning a request to begin a run; sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1, meaning a synchronous cancel of the current run.
REQ-007 The block SHALL have port seed_a, input, WIDTH, meaning term 0.
REQ-008 The block SHALL have port seed_b, input, WIDTH, meaning term 1.
REQ-009 The block SHALL have port num_terms, input, CNT_W, meaning the maximum number of terms to emit.
REQ-010 The block SHALL have port mode, input, 2, meaning overflow policy: 0 wrap, 1 saturate, 2 stop, 3 treated as wrap.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the consumer accepts out_data.
REQ-012 The block SHALL have port out_valid, output, 1, meaning out_data holds a valid term.
REQ-013 The block SHALL have port out_data, output, WIDTH, meaning the current term.
REQ-014 The block SHALL have port out_last, output, 1, meaning the current term is the final term of the run.
REQ-015 The block SHALL have port term_idx, output, CNT_W, meaning the zero-based index of out_data.
REQ-016 The block SHALL have port busy, output, 1, meaning the block is in state EMIT.
REQ-017 The block SHALL have port done, output, 1, meaning a one-cycle pulse at normal run completion.
REQ-018 The block SHALL have port overflow, output, 1, meaning a sticky flag that some computed term exceeded WIDTH bits this run.

Function
REQ-019 The block SHALL implement states IDLE and EMIT.
REQ-020 In IDLE with start=1 and num_terms!=0, the block SHALL latch seed_a into cur, seed_b into nxt, num_terms into rem and mode, clear nxt_ovf, overflow and term_idx, and enter EMIT next cycle.
REQ-021 In IDLE with start=1 and num_terms=0, the block SHALL stay in IDLE, emit nothing and pulse done the following cycle.
REQ-022 In EMIT the block SHALL drive out_valid=1, out_data=cur, and out_last = (rem==1) OR (latched mode==2 AND nxt_ovf).
REQ-023 While out_valid=1 and out_ready=0, out_data, out_last and term_idx SHALL be held stable.
REQ-024 On a transfer (out_valid AND out_ready) with out_last=0, the block SHALL update cur<=nxt, nxt<=f(cur+nxt), nxt_ovf<=carry, rem<=rem-1 and term_idx<=term_idx+1.
REQ-025 The sum cur+nxt SHALL be computed at WIDTH+1 bits; carry is bit WIDTH.
REQ-026 Function f SHALL pass the low WIDTH bits for wrap and stop, and SHALL force all-ones on carry for saturate.
REQ-027 overflow SHALL be set on any cycle that latches carry=1 into nxt_ovf and SHALL hold until the next accepted start or reset.
REQ-028 On a transfer with out_last=1, the block SHALL return to IDLE and pulse done for exactly one cycle, in the cycle after the transfer.
REQ-029 A term with nxt_ovf set SHALL never be emitted in stop mode.
REQ-030 abort=1 in EMIT SHALL force IDLE on the next edge, with out_valid=0 from that cycle and no done pulse; abort SHALL take priority over a simultaneous transfer.
REQ-031 start asserted during EMIT SHALL be ignored.
REQ-032 Seed and mode changes during EMIT SHALL have no effect on the current run.

Reset
REQ-033 While rst=1, independent of clk, the block SHALL be in IDLE with out_valid=0, out_data=0, out_last=0, term_idx=0, busy=0, done=0 and overflow=0.
REQ-034 Reset asserted mid-run SHALL discard the run with no done pulse, and after release the block SHALL accept a new start.

Verification
REQ-035 The bench SHALL cover: WIDTH=8, seeds 0/1, num_terms=10, mode 0, out_ready=1 -> 0,1,1,2,3,5,8,13,21,34, with out_last on 34 and done one cycle later.
REQ-036 The bench SHALL cover: WIDTH=8, seeds 0/1, num_terms=20, mode 2 -> 14 terms ending 233 at term_idx=13 with out_last=1, and overflow=1.
REQ-037 The bench SHALL cover: same as REQ-036 in mode 0 -> term 14 is 121, and in mode 1 -> term 14 is 255 and every later term is 255.
REQ-038 The bench SHALL cover: random out_ready backpressure on run 0/1 with 12 terms -> identical term stream, with out_data stable while stalled.
REQ-039 The bench SHALL cover: abort at term_idx=4, then rst pulsed mid-run on a second run -> out_valid drops, no done, and a following start 2/1 with 5 terms produces 2,1,3,4,7.
REQ-040 The bench SHALL cover: start with num_terms=0 -> no out_valid and a single done pulse.
